// File: rtl/sha_256_msg_padder.sv
// SHA-256 message padder: packs a byte stream big-endian into 512-bit blocks and appends
// the 0x80 marker, zero fill and 64-bit message bit length.
//
// state    | meaning
// S_ACCEPT | taking message bytes into the block buffer
// S_PAD    | one cycle: write 0x80, zero fill and (if room) the length field
// S_EMIT   | presenting block_data_o until the downstream handshake
// S_LEN    | one cycle: build a length-only block when the pad block had no room
module sha_256_msg_padder #(
    parameter int LEN_W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   in_data_i,
    input  logic         in_valid_i,
    input  logic         in_last_i,
    output logic         in_ready_o,
    output logic [511:0] block_data_o,
    output logic         block_valid_o,
    output logic         block_last_o,
    input  logic         block_ready_i,
    output logic         busy_o
);

    typedef enum logic [1:0] {
        S_ACCEPT = 2'd0,
        S_PAD    = 2'd1,
        S_EMIT   = 2'd2,
        S_LEN    = 2'd3
    } state_t;

    state_t             state_q;
    logic [5:0]         ptr_q;
    logic [LEN_W-1:0]   bitlen_q;
    logic [511:0]       buf_q;
    logic               valid_q;
    logic               last_q;
    logic               pend_pad_q;
    logic               pend_len_q;

    logic [8:0]         wr_lsb_d;
    logic [63:0]        len64_d;
    logic [511:0]       pad_blk_d;
    logic [511:0]       len_blk_d;

    // Slot 0 lives in the top byte, so slot p occupies bits [504-8p +: 8].
    assign wr_lsb_d = 9'd504 - {ptr_q, 3'b000};
    assign len64_d  = 64'(bitlen_q);

    always_comb begin
        pad_blk_d = buf_q;
        for (int s = 0; s < 64; s++) begin
            if (6'(s) == ptr_q) begin
                pad_blk_d[504 - 8*s +: 8] = 8'h80;
            end else if (6'(s) > ptr_q) begin
                pad_blk_d[504 - 8*s +: 8] = 8'h00;
            end
        end
        if (ptr_q <= 6'd55) begin
            pad_blk_d[63:0] = len64_d;
        end
        len_blk_d = {448'b0, len64_d};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_ACCEPT;
            ptr_q      <= '0;
            bitlen_q   <= '0;
            buf_q      <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            pend_pad_q <= 1'b0;
            pend_len_q <= 1'b0;
        end else begin
            case (state_q)
                S_ACCEPT: begin
                    if (in_valid_i) begin
                        buf_q[wr_lsb_d +: 8] <= in_data_i;
                        ptr_q                <= ptr_q + 6'd1;
                        bitlen_q             <= bitlen_q + LEN_W'(8);
                        if (ptr_q == 6'd63) begin
                            // Full block; a final 64th byte still owes a pad block.
                            state_q    <= S_EMIT;
                            valid_q    <= 1'b1;
                            last_q     <= 1'b0;
                            pend_pad_q <= in_last_i;
                        end else if (in_last_i) begin
                            state_q <= S_PAD;
                        end
                    end
                end
                S_PAD: begin
                    buf_q   <= pad_blk_d;
                    valid_q <= 1'b1;
                    state_q <= S_EMIT;
                    if (ptr_q <= 6'd55) begin
                        last_q <= 1'b1;
                    end else begin
                        last_q     <= 1'b0;
                        pend_len_q <= 1'b1;
                    end
                end
                S_EMIT: begin
                    if (block_ready_i) begin
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        ptr_q   <= '0;
                        buf_q   <= '0;
                        if (pend_pad_q) begin
                            state_q    <= S_PAD;
                            pend_pad_q <= 1'b0;
                        end else if (pend_len_q) begin
                            state_q    <= S_LEN;
                            pend_len_q <= 1'b0;
                        end else begin
                            state_q <= S_ACCEPT;
                            if (last_q) begin
                                bitlen_q <= '0;
                            end
                        end
                    end
                end
                S_LEN: begin
                    buf_q   <= len_blk_d;
                    last_q  <= 1'b1;
                    valid_q <= 1'b1;
                    state_q <= S_EMIT;
                end
                default: begin
                    state_q <= S_ACCEPT;
                end
            endcase
        end
    end

    assign in_ready_o    = (state_q == S_ACCEPT);
    assign block_data_o  = buf_q;
    assign block_valid_o = valid_q;
    assign block_last_o  = last_q;
    assign busy_o        = (state_q != S_ACCEPT) || (ptr_q != 6'd0);

endmodule

// File: tb/tb_sha_256_msg_padder.sv
// Bench for sha_256_msg_padder: directed and random messages checked against a
// queue-based FIPS 180-4 padding model, with random gaps and downstream backpressure.
module tb_sha_256_msg_padder;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   in_data_i;
    logic         in_valid_i;
    logic         in_last_i;
    logic         in_ready_o;
    logic [511:0] block_data_o;
    logic         block_valid_o;
    logic         block_last_o;
    logic         block_ready_i;
    logic         busy_o;

    int n_cmp = 0;
    int n_err = 0;

    logic [511:0] exp_blk[$];
    logic         exp_last[$];

    sha_256_msg_padder #(.LEN_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_data_i     (in_data_i),
        .in_valid_i    (in_valid_i),
        .in_last_i     (in_last_i),
        .in_ready_o    (in_ready_o),
        .block_data_o  (block_data_o),
        .block_valid_o (block_valid_o),
        .block_last_o  (block_last_o),
        .block_ready_i (block_ready_i),
        .busy_o        (busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input logic [511:0] obs, input logic [511:0] exp, input string tag);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference padding: message, 0x80, zeros to 56 mod 64, 64-bit big-endian bit length.
    task automatic build_exp(input logic [7:0] msg[$]);
        logic [7:0]   p[$];
        logic [63:0]  bits;
        logic [511:0] blk;
        int           nb;
        p = msg;
        p.push_back(8'h80);
        while ((p.size() % 64) != 56) p.push_back(8'h00);
        bits = 64'(32'(msg.size() * 8));
        for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
        exp_blk.delete();
        exp_last.delete();
        nb = p.size() / 64;
        for (int b = 0; b < nb; b++) begin
            for (int j = 0; j < 64; j++) blk[504 - 8*j +: 8] = p[64*b + j];
            exp_blk.push_back(blk);
            exp_last.push_back(b == nb - 1);
        end
    endtask

    task automatic run_msg(input logic [7:0] msg[$], input int hold, input string tag);
        int idx, nblk, cycles, close_idx, close_cyc, exp_lat, held;
        bit first_seen;
        build_exp(msg);
        close_idx  = (msg.size() >= 64) ? 63 : msg.size() - 1;
        exp_lat    = (msg.size() >= 64) ? 1 : 2;
        idx        = 0;
        nblk       = 0;
        cycles     = 0;
        held       = 0;
        close_cyc  = -100;
        first_seen = 1'b0;
        while (nblk < exp_blk.size() && cycles < 4000) begin
            @(negedge clk);
            cycles++;
            if (block_valid_o) begin
                if (!first_seen) begin
                    first_seen = 1'b1;
                    chk(512'(cycles - close_cyc), 512'(exp_lat), {tag, " latency"});
                end
                chk(512'(in_ready_o), 512'(0), {tag, " in_ready during emit"});
                chk(block_data_o, exp_blk[nblk], {tag, $sformatf(" block%0d data", nblk)});
                chk(512'(block_last_o), 512'(exp_last[nblk]), {tag, $sformatf(" block%0d last", nblk)});
                if (held < hold) begin
                    held++;
                    block_ready_i = 1'b0;
                end else begin
                    block_ready_i = ($urandom_range(0, 3) != 0);
                    if (block_ready_i) begin
                        nblk++;
                        held = 0;
                    end
                end
            end else begin
                block_ready_i = 1'($urandom_range(0, 1));
            end
            if (in_ready_o && idx < msg.size() && $urandom_range(0, 3) != 0) begin
                in_valid_i = 1'b1;
                in_data_i  = msg[idx];
                in_last_i  = (idx == msg.size() - 1);
                if (idx == close_idx) close_cyc = cycles;
                idx++;
            end else begin
                in_valid_i = 1'b0;
                in_data_i  = 8'($urandom);
                in_last_i  = 1'($urandom);
            end
        end
        chk(512'(nblk), 512'(exp_blk.size()), {tag, " blocks taken"});
        @(negedge clk);
        block_ready_i = 1'b0;
        in_valid_i    = 1'b0;
        in_last_i     = 1'b0;
        chk(512'({block_valid_o, in_ready_o, busy_o}), 512'(3'b010), {tag, " idle after message"});
    endtask

    task automatic chk_reset_state(input string tag);
        chk(512'({in_ready_o, block_valid_o, block_last_o, busy_o}), 512'(4'b1000), {tag, " reset flags"});
        chk(block_data_o, 512'(0), {tag, " reset data"});
    endtask

    initial begin
        logic [7:0] m[$];
        rst           = 1'b1;
        in_data_i     = 8'h00;
        in_valid_i    = 1'b0;
        in_last_i     = 1'b0;
        block_ready_i = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_reset_state("por");

        m = '{8'h61, 8'h62, 8'h63};
        run_msg(m, 0, "abc");

        m.delete();
        for (int i = 0; i < 55; i++) m.push_back(8'h00);
        run_msg(m, 0, "zeros55");

        m.delete();
        for (int i = 0; i < 56; i++) m.push_back(8'h00);
        run_msg(m, 0, "zeros56");

        m.delete();
        for (int i = 0; i < 64; i++) m.push_back(8'(i));
        run_msg(m, 0, "ramp64");

        m = '{8'h61, 8'h62, 8'h63};
        run_msg(m, 10, "abc_backpressure");

        foreach (m[i]) m[i] = 8'($urandom);
        for (int L = 63; L <= 128; L += 65) begin
            m.delete();
            for (int i = 0; i < L; i++) m.push_back(8'($urandom));
            run_msg(m, 3, $sformatf("edge_len%0d", L));
        end
        m.delete();
        for (int i = 0; i < 120; i++) m.push_back(8'($urandom));
        run_msg(m, 2, "len120");

        // Abandon a message after 20 bytes and restart cleanly.
        for (int i = 0; i < 20; i++) begin
            in_valid_i = 1'b1;
            in_data_i  = 8'($urandom);
            in_last_i  = 1'b0;
            @(negedge clk);
        end
        in_valid_i = 1'b0;
        rst        = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_reset_state("midmsg_reset");
        m = '{8'h61, 8'h62, 8'h63};
        run_msg(m, 0, "abc_after_reset");

        for (int t = 0; t < 25; t++) begin
            int L;
            L = $urandom_range(1, 150);
            m.delete();
            for (int i = 0; i < L; i++) m.push_back(8'($urandom));
            run_msg(m, $urandom_range(0, 4), $sformatf("rand%0d_len%0d", t, L));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
